ddc_agc_gain: RTL

Multi-channel digital gain stage with automatic gain control, placed between the DDC filter output and the 18-bit downstream datapath. Each of NUM_CH signed lanes is right-shifted with round-half-up and saturated to OUTPUT_WIDTH. A windowed peak detector spans all lanes and drives the shift, either from a manual setting or from an attack-fast/decay-slow AGC loop. Window peaks are also reported for software monitoring.

---
 rtl/ddc_gain_pkg.sv | 42 ++++
 rtl/gain_lane.sv | 94 +++++++++
 rtl/ddc_agc_gain.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/ddc_gain_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ddc_gain_pkg
// Description : Shared defaults, lane-slicing helpers, bit-length and clamp
//               functions for the DDC AGC gain stage.
// Revision    : 1.0 - initial release
// ============================================================================
package ddc_gain_pkg;

  // Default build of the gain stage: I/Q lanes, 34-bit in, 18-bit out
  localparam int DEF_NUM_CH       = 2;
  localparam int DEF_INPUT_WIDTH  = 34;
  localparam int DEF_OUTPUT_WIDTH = 18;
  localparam int DEF_MAX_SHIFT    = 16;
  localparam int DEF_SHIFT_WIDTH  = 5;
  localparam int DEF_WIN_WIDTH    = 16;
  localparam int DEF_HEADROOM     = 1;

  // LSB position of lane 'lane' in a bus of 'width'-bit lanes
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

  // Number of bits needed to represent v (0 for v == 0)
  function automatic int bitlen(input logic [63:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 64; i++) begin
      if (v[i]) n = i + 1;
    end
    return n;
  endfunction

  // Clamp v into [lo, hi]
  function automatic int clamp_int(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage : ddc_gain_pkg
`default_nettype wire

// File: rtl/gain_lane.sv
`default_nettype none
// ============================================================================
// Module      : gain_lane
// Description : One lane of the gain stage: round-half-up, arithmetic right
//               shift and saturation, two register stages.
// Revision    : 1.0 - initial release
// ============================================================================
module gain_lane
  import ddc_gain_pkg::*;
#(
  parameter int INPUT_WIDTH  = DEF_INPUT_WIDTH,
  parameter int OUTPUT_WIDTH = DEF_OUTPUT_WIDTH,
  parameter int SHIFT_WIDTH  = DEF_SHIFT_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    nd,
  input  logic [INPUT_WIDTH-1:0]  din,
  input  logic [SHIFT_WIDTH-1:0]  shift,
  output logic                    rdy,
  output logic [OUTPUT_WIDTH-1:0] dout,
  output logic                    sat
);

  // One extra bit so the rounding offset can never overflow the sum
  localparam int TW = INPUT_WIDTH + 1;

  localparam logic signed [TW-1:0] OUT_MAX =
    {{(TW - OUTPUT_WIDTH + 1){1'b0}}, {(OUTPUT_WIDTH-1){1'b1}}};
  localparam logic signed [TW-1:0] OUT_MIN =
    {{(TW - OUTPUT_WIDTH + 1){1'b1}}, {(OUTPUT_WIDTH-1){1'b0}}};

  logic        [TW-1:0]          half;
  logic signed [TW-1:0]          sum;
  logic signed [TW-1:0]          t1;
  logic        [SHIFT_WIDTH-1:0] s1;
  logic                          v1;
  logic signed [TW-1:0]          y;
  logic        [OUTPUT_WIDTH-1:0] y_sat;
  logic                          clip;

  // Rounding offset 2^(s-1) added to the sign-extended input
  always_comb begin
    half = '0;
    if (shift != '0) half = TW'(1) << (shift - 1'b1);
    sum = $signed({din[INPUT_WIDTH-1], din} + half);
  end

  // Stage 1: register the rounded sum together with the shift it belongs to
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      t1 <= '0;
      s1 <= '0;
    end else begin
      v1 <= nd;
      if (nd) begin
        t1 <= sum;
        s1 <= shift;
      end
    end
  end

  // Arithmetic shift (floor) followed by clipping to the output range
  always_comb begin
    y     = t1 >>> s1;
    clip  = 1'b0;
    y_sat = y[OUTPUT_WIDTH-1:0];
    if (y > OUT_MAX) begin
      clip  = 1'b1;
      y_sat = OUT_MAX[OUTPUT_WIDTH-1:0];
    end else if (y < OUT_MIN) begin
      clip  = 1'b1;
      y_sat = OUT_MIN[OUTPUT_WIDTH-1:0];
    end
  end

  // Stage 2: register the saturated result, its flag and valid
  always_ff @(posedge clk) begin
    if (rst) begin
      rdy  <= 1'b0;
      dout <= '0;
      sat  <= 1'b0;
    end else begin
      rdy <= v1;
      if (v1) begin
        dout <= y_sat;
        sat  <= clip;
      end
    end
  end

endmodule : gain_lane
`default_nettype wire

// File: rtl/ddc_agc_gain.sv
`default_nettype none
// ============================================================================
// Module      : ddc_agc_gain
// Description : Multi-lane gain stage with windowed peak detection and an
//               attack-fast / decay-slow automatic gain control loop.
// Revision    : 1.0 - initial release
// ============================================================================
module ddc_agc_gain
  import ddc_gain_pkg::*;
#(
  parameter int NUM_CH       = DEF_NUM_CH,
  parameter int INPUT_WIDTH  = DEF_INPUT_WIDTH,
  parameter int OUTPUT_WIDTH = DEF_OUTPUT_WIDTH,
  parameter int MAX_SHIFT    = DEF_MAX_SHIFT,
  parameter int SHIFT_WIDTH  = DEF_SHIFT_WIDTH,
  parameter int WIN_WIDTH    = DEF_WIN_WIDTH,
  parameter int HEADROOM     = DEF_HEADROOM
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           mode,
  input  logic [SHIFT_WIDTH-1:0]         shift_manual,
  input  logic [WIN_WIDTH-1:0]           win_len,
  input  logic                           nd,
  input  logic [NUM_CH*INPUT_WIDTH-1:0]  data_in,
  output logic                           rdy,
  output logic [NUM_CH*OUTPUT_WIDTH-1:0] data_out,
  output logic [NUM_CH-1:0]              sat,
  output logic [SHIFT_WIDTH-1:0]         shift_cur,
  output logic [INPUT_WIDTH-1:0]         peak_out,
  output logic                           peak_valid
);

  // Peak bit length that maps to zero shift (full scale minus headroom)
  localparam int AGC_OFFSET = OUTPUT_WIDTH - 1 - HEADROOM;

  localparam logic [SHIFT_WIDTH-1:0] MAX_SHIFT_V = SHIFT_WIDTH'(MAX_SHIFT);
  localparam logic [INPUT_WIDTH-1:0] MAG_MAX  = {1'b0, {(INPUT_WIDTH-1){1'b1}}};
  localparam logic [INPUT_WIDTH-1:0] NEG_FULL = {1'b1, {(INPUT_WIDTH-1){1'b0}}};

  logic [NUM_CH-1:0]             lane_rdy;
  logic [NUM_CH*INPUT_WIDTH-1:0] mag_flat;
  logic [INPUT_WIDTH-1:0]        sample_max;
  logic [INPUT_WIDTH-1:0]        acc;
  logic [INPUT_WIDTH-1:0]        win_peak;
  logic [WIN_WIDTH-1:0]          cnt;
  logic [WIN_WIDTH-1:0]          len;
  logic [WIN_WIDTH-1:0]          len_eff;
  logic                          close;
  logic [SHIFT_WIDTH-1:0]        target;
  logic [SHIFT_WIDTH-1:0]        manual_clamped;

  generate
    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
      logic [INPUT_WIDTH-1:0] din_k;
      assign din_k = data_in[lane_lsb(k, INPUT_WIDTH) +: INPUT_WIDTH];

      // Magnitude; the most negative input folds onto the largest positive
      assign mag_flat[lane_lsb(k, INPUT_WIDTH) +: INPUT_WIDTH] =
        (din_k == NEG_FULL) ? MAG_MAX :
        (din_k[INPUT_WIDTH-1] ? (-din_k) : din_k);

      gain_lane #(
        .INPUT_WIDTH  (INPUT_WIDTH),
        .OUTPUT_WIDTH (OUTPUT_WIDTH),
        .SHIFT_WIDTH  (SHIFT_WIDTH)
      ) u_lane (
        .clk   (clk),
        .rst   (rst),
        .nd    (nd),
        .din   (din_k),
        .shift (shift_cur),
        .rdy   (lane_rdy[k]),
        .dout  (data_out[lane_lsb(k, OUTPUT_WIDTH) +: OUTPUT_WIDTH]),
        .sat   (sat[k])
      );
    end
  endgenerate

  // All lanes run in lockstep, so their valids are identical
  assign rdy = &lane_rdy;

  // Largest lane magnitude this cycle, merged into the running window peak
  always_comb begin
    sample_max = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (mag_flat[k*INPUT_WIDTH +: INPUT_WIDTH] > sample_max)
        sample_max = mag_flat[k*INPUT_WIDTH +: INPUT_WIDTH];
    end
    win_peak = (sample_max > acc) ? sample_max : acc;
  end

  // Window length is latched on the first sample; zero behaves as one
  always_comb begin
    if (cnt == '0)
      len_eff = (win_len == '0) ? WIN_WIDTH'(1) : win_len;
    else
      len_eff = len;
    close = nd && (cnt == (len_eff - WIN_WIDTH'(1)));
  end

  // AGC target shift and clamped manual shift
  always_comb begin
    target = SHIFT_WIDTH'(clamp_int(bitlen(64'(win_peak)) - AGC_OFFSET, 0, MAX_SHIFT));
    manual_clamped = (shift_manual > MAX_SHIFT_V) ? MAX_SHIFT_V : shift_manual;
  end

  // Window sample counter and peak accumulator
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      len <= '0;
      acc <= '0;
    end else if (nd) begin
      if (cnt == '0) len <= len_eff;
      if (close) begin
        cnt <= '0;
        acc <= '0;
      end else begin
        cnt <= cnt + WIN_WIDTH'(1);
        acc <= win_peak;
      end
    end
  end

  // Completed-window peak report
  always_ff @(posedge clk) begin
    if (rst) begin
      peak_out   <= '0;
      peak_valid <= 1'b0;
    end else begin
      peak_valid <= close;
      if (close) peak_out <= win_peak;
    end
  end

  // Shift register: manual follows the input, AGC updates only at window close
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_cur <= '0;
    end else if (!mode) begin
      shift_cur <= manual_clamped;
    end else if (close) begin
      if (target >= shift_cur)
        shift_cur <= target;
      else
        shift_cur <= shift_cur - 1'b1;
    end
  end

endmodule : ddc_agc_gain
`default_nettype wire
